// File: rtl/stroke_feature_extractor_pkg.sv
// Shared definitions for the stroke front end of the digit perceptron:
// stroke token codes, default feature widths and FSM state encodings.
package stroke_feature_extractor_pkg;

    localparam int DEFAULT_EDGE_W  = 3;
    localparam int DEFAULT_CURVE_W = 4;

    typedef enum logic [1:0] {
        STROKE_SKIP  = 2'b00,
        STROKE_EDGE  = 2'b01,
        STROKE_CURVE = 2'b10,
        STROKE_EOG   = 2'b11
    } stroke_code_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/stroke_feature_extractor_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// A clear request takes priority over an increment in the same cycle.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         at_max_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max_o = (count_q == {W{1'b1}});
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !at_max_o) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stroke_feature_extractor.sv
// Counts edge and curve strokes of one glyph and hands the (edges, curves, sat)
// feature pair to the perceptron over a valid/ready handshake at end of glyph.
module stroke_feature_extractor
    import stroke_feature_extractor_pkg::*;
#(
    parameter int EDGE_W  = DEFAULT_EDGE_W,
    parameter int CURVE_W = DEFAULT_CURVE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stroke_valid,
    output logic               stroke_ready,
    input  logic [1:0]         stroke_code,
    output logic               feat_valid,
    input  logic               feat_ready,
    output logic [EDGE_W-1:0]  edges,
    output logic [CURVE_W-1:0] curves,
    output logic               sat
);

    state_e               state_q;
    logic                 featValid_q;
    logic [EDGE_W-1:0]    edgesOut_q;
    logic [CURVE_W-1:0]   curvesOut_q;
    logic                 satOut_q;
    logic                 satAcc_q;
    logic                 satAcc_d;

    logic                 strokeFire;
    logic                 isEdge;
    logic                 isCurve;
    logic                 isEog;
    logic                 eogLoad;
    logic [EDGE_W-1:0]    edgeCount;
    logic [CURVE_W-1:0]   curveCount;
    logic                 edgeAtMax;
    logic                 curveAtMax;

    assign stroke_ready = (state_q != HOLD);
    assign strokeFire   = stroke_valid && stroke_ready;
    assign isEdge       = strokeFire && (stroke_code == STROKE_EDGE);
    assign isCurve      = strokeFire && (stroke_code == STROKE_CURVE);
    assign isEog        = strokeFire && (stroke_code == STROKE_EOG);
    // An EOG in IDLE is an empty glyph and must not disturb anything.
    assign eogLoad      = isEog && (state_q == ACCUM);

    sat_counter #(.W(EDGE_W)) u_edgeCounter (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (eogLoad),
        .inc_i   (isEdge),
        .count_o (edgeCount),
        .at_max_o(edgeAtMax)
    );

    sat_counter #(.W(CURVE_W)) u_curveCounter (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (eogLoad),
        .inc_i   (isCurve),
        .count_o (curveCount),
        .at_max_o(curveAtMax)
    );

    always_comb begin
        satAcc_d = satAcc_q;
        if (eogLoad) begin
            satAcc_d = 1'b0;
        end else if ((isEdge && edgeAtMax) || (isCurve && curveAtMax)) begin
            satAcc_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            featValid_q <= 1'b0;
            edgesOut_q  <= '0;
            curvesOut_q <= '0;
            satOut_q    <= 1'b0;
            satAcc_q    <= 1'b0;
        end else begin
            satAcc_q <= satAcc_d;
            case (state_q)
                IDLE: begin
                    if (isEdge || isCurve) begin
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (isEog) begin
                        edgesOut_q  <= edgeCount;
                        curvesOut_q <= curveCount;
                        satOut_q    <= satAcc_q;
                        featValid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (feat_ready) begin
                        featValid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign feat_valid = featValid_q;
    assign edges      = edgesOut_q;
    assign curves     = curvesOut_q;
    assign sat        = satOut_q;

endmodule
